// File: rtl/vm_sequencer.sv
// Tiny memory-to-memory sequencer: fetches 32-bit words from a 16-word memory and runs NOP/HALT/MV/JMP.
// Define VM_SEQ_ADD_EN to add opcode 0x0A (ADD) and its RD_DST state; otherwise 0x0A is illegal.
module vm_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] mem_addr,
    output logic        mem_rw,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HALT = 8'h01;
    localparam logic [7:0] OP_MV   = 8'h09;
    localparam logic [7:0] OP_JMP  = 8'h0C;
`ifdef VM_SEQ_ADD_EN
    localparam logic [7:0] OP_ADD  = 8'h0A;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_RD_SRC, S_RD_DST, S_WRITE, S_HALT
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] op_a;
`ifdef VM_SEQ_ADD_EN
    logic [31:0] op_b;
`endif
    logic        armed;
    logic [7:0]  opcode, src, dst;
    logic [7:0]  unused_ir_hi;
    logic        src_ok, dst_ok;
    logic [3:0]  pc_inc;
    logic [31:0] result;

    assign opcode       = ir[7:0];
    assign src          = ir[15:8];
    assign dst          = ir[23:16];
    assign unused_ir_hi = ir[31:24];
    assign src_ok       = (src[7:4] == 4'd0);
    assign dst_ok       = (dst[7:4] == 4'd0);
    assign pc_inc       = pc + 4'd1;

`ifdef VM_SEQ_ADD_EN
    assign result = (opcode == OP_ADD) ? op_a + op_b : op_a;
`else
    assign result = op_a;
`endif

    // Memory bus is a pure decode of the state register, so an async reset drops mem_rw with no edge.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mem_addr  = '0;
        mem_rw    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_FETCH, S_DECODE: mem_addr = {12'd0, pc};
            S_RD_SRC:          mem_addr = {8'd0, src};
            S_RD_DST:          mem_addr = {8'd0, dst};
            S_WRITE: begin
                mem_addr  = {8'd0, dst};
                mem_rw    = 1'b1;
                mem_wdata = result;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            op_a   <= '0;
`ifdef VM_SEQ_ADD_EN
            op_b   <= '0;
`endif
            err    <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
            armed  <= 1'b0;
        end else begin
            // armed keeps start from being honoured on the first edge after reset release
            armed <= 1'b1;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start && armed) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= mem_rdata;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP: begin
                            pc    <= pc_inc;
                            state <= S_FETCH;
                        end
                        OP_HALT: begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        OP_JMP: begin
                            state <= S_FETCH;
                            if (src_ok) begin
                                pc <= src[3:0];
                            end else begin
                                pc  <= pc_inc;
                                err <= 1'b1;
                            end
                        end
`ifdef VM_SEQ_ADD_EN
                        OP_MV, OP_ADD: begin
`else
                        OP_MV: begin
`endif
                            if (src_ok && dst_ok) begin
                                state <= S_RD_SRC;
                            end else begin
                                pc    <= pc_inc;
                                err   <= 1'b1;
                                state <= S_FETCH;
                            end
                        end
                        default: begin
                            pc    <= pc_inc;
                            err   <= 1'b1;
                            state <= S_FETCH;
                        end
                    endcase
                end
                S_RD_SRC: begin
                    op_a <= mem_rdata;
`ifdef VM_SEQ_ADD_EN
                    state <= (opcode == OP_ADD) ? S_RD_DST : S_WRITE;
`else
                    state <= S_WRITE;
`endif
                end
`ifdef VM_SEQ_ADD_EN
                S_RD_DST: begin
                    op_b  <= mem_rdata;
                    state <= S_WRITE;
                end
`endif
                S_WRITE: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_sequencer.sv
// Self-checking bench for vm_sequencer: table of single-instruction programs plus hand-written
// sequences for jump, pc wrap, early start after reset and reset during a write.
module tb_vm_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rw;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  pc;
    logic        busy, halted, err;

    vm_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pc(pc), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    // Memory model: preload image plus a write overlay, so the bench process alone owns the image.
    logic [31:0] pre [16];
    logic [31:0] wr_data [16];
    logic        wr_valid [16];
    logic        seen [16];
    logic        clr = 1'b0;
    int          write_count = 0;
    int          addr_hi_bad = 0;
    int          wdata_bad = 0;
    int          errors = 0;
    int          checks = 0;

    always_comb begin
        mem_rdata = wr_valid[mem_addr[3:0]] ? wr_data[mem_addr[3:0]] : pre[mem_addr[3:0]];
    end

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                wr_valid[i] <= 1'b0;
                seen[i]     <= 1'b0;
            end
            write_count <= 0;
        end else begin
            if (mem_rw) begin
                wr_valid[mem_addr[3:0]] <= 1'b1;
                wr_data[mem_addr[3:0]]  <= mem_wdata;
                write_count             <= write_count + 1;
            end
            if (busy && !mem_rw) seen[mem_addr[3:0]] <= 1'b1;
            if (mem_addr[15:4] != 12'd0) addr_hi_bad <= addr_hi_bad + 1;
        end
    end

    always @(negedge clk) begin
        if (!mem_rw && mem_wdata != 32'd0) wdata_bad <= wdata_bad + 1;
    end

    function automatic logic [31:0] mem_val(input logic [3:0] a);
        return wr_valid[a] ? wr_data[a] : pre[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        clr   = 1'b1;
        #1 clr = 1'b0;
        for (int i = 0; i < 16; i++) pre[i] = 32'd0;
    endtask

    // Leaves the bench at the negedge after the first rising edge following release.
    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Pulses start and counts rising edges (start edge included) until halted, bounded.
    task automatic run(output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!halted && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!halted) cyc = -1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  ra;
        logic [31:0] va;
        logic [3:0]  rb;
        logic [31:0] vb;
        logic [3:0]  chk_addr;
        logic [31:0] chk_val;
        logic        exp_err;
        int          exp_writes;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cyc;
        logic any_seen;

        vecs[0] = '{"mv",         32'h000A0209, 4'd2, 32'h12345678, 4'd3, 32'h0,        4'd10, 32'h12345678, 1'b0, 1, 7};
        vecs[1] = '{"nop",        32'h00000000, 4'd2, 32'h11111111, 4'd3, 32'h22222222, 4'd3,  32'h22222222, 1'b0, 0, 5};
        vecs[2] = '{"mv_bad_src", 32'h00001409, 4'd2, 32'h5,        4'd3, 32'h6,        4'd0,  32'h00001409, 1'b1, 0, 5};
        vecs[3] = '{"bad_op",     32'h0000007F, 4'd2, 32'h5,        4'd3, 32'h6,        4'd2,  32'h5,        1'b1, 0, 5};
        vecs[4] = '{"mv_bad_dst", 32'h00F00209, 4'd2, 32'hABCD0123, 4'd3, 32'h0,        4'd2,  32'hABCD0123, 1'b1, 0, 5};
        vecs[5] = '{"mv_5_6",     32'h00060509, 4'd5, 32'hA5A5A5A5, 4'd6, 32'h0,        4'd6,  32'hA5A5A5A5, 1'b0, 1, 7};
        vecs[6] = '{"jmp1",       32'h0000010C, 4'd2, 32'h7,        4'd3, 32'h8,        4'd2,  32'h7,        1'b0, 0, 5};
        vecs[7] = '{"jmp_bad",    32'h0000200C, 4'd2, 32'h7,        4'd3, 32'h8,        4'd2,  32'h7,        1'b1, 0, 5};
`ifdef VM_SEQ_ADD_EN
        vecs[8] = '{"add",        32'h0004030A, 4'd3, 32'hFFFFFFFF, 4'd4, 32'h2,        4'd4,  32'h00000001, 1'b0, 1, 8};
`else
        vecs[8] = '{"add",        32'h0004030A, 4'd3, 32'hFFFFFFFF, 4'd4, 32'h2,        4'd4,  32'h00000002, 1'b1, 0, 5};
`endif
        vecs[9] = '{"mv_same",    32'h00070709, 4'd7, 32'h0BADF00D, 4'd3, 32'h0,        4'd7,  32'h0BADF00D, 1'b0, 1, 7};

        // Reset state
        for (int i = 0; i < 16; i++) pre[i] = 32'd0;
        #1 rst = 1'b0;
        #1;
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // Start on the first edge after release is ignored
        hold_reset();
        pre[1] = 32'h1;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("early_start_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("early_start_still_idle", {31'd0, busy}, 32'd0);

        // Table of single-instruction programs, each followed by HALT at address 1
        for (int v = 0; v < 10; v++) begin
            hold_reset();
            pre[0]           = vecs[v].instr;
            pre[1]           = 32'h1;
            pre[vecs[v].ra]  = vecs[v].va;
            pre[vecs[v].rb]  = vecs[v].vb;
            release_reset();
            run(cyc);
            check({vecs[v].name, "_cycles"}, cyc, vecs[v].exp_cycles);
            check({vecs[v].name, "_halted"}, {31'd0, halted}, 32'd1);
            check({vecs[v].name, "_pc"}, {28'd0, pc}, 32'd1);
            check({vecs[v].name, "_err"}, {31'd0, err}, {31'd0, vecs[v].exp_err});
            check({vecs[v].name, "_mem"}, mem_val(vecs[v].chk_addr), vecs[v].chk_val);
            check({vecs[v].name, "_writes"}, write_count, vecs[v].exp_writes);
            check({vecs[v].name, "_halt_addr"}, {16'd0, mem_addr}, 32'd0);
        end

        // JMP over a block: addresses 1..4 must never be touched
        hold_reset();
        pre[0] = 32'h0000050C;
        pre[1] = 32'h1;
        pre[5] = 32'h1;
        release_reset();
        run(cyc);
        check("jmp5_pc", {28'd0, pc}, 32'd5);
        check("jmp5_halted", {31'd0, halted}, 32'd1);
        any_seen = seen[1] | seen[2] | seen[3] | seen[4];
        check("jmp5_skipped_fetch", {31'd0, any_seen}, 32'd0);

        // pc wrap: JMP 15, NOP at 15 increments to 0, mem[0] re-executes
        hold_reset();
        pre[0] = 32'h00000F0C;
        release_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("wrap_jmp_pc", {28'd0, pc}, 32'd15);
        repeat (2) @(negedge clk);
        check("wrap_pc_zero", {28'd0, pc}, 32'd0);
        check("wrap_fetch_addr", {16'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        check("wrap_reexec_pc", {28'd0, pc}, 32'd15);

        // Reset asserted mid-WRITE of an MV: write must be abandoned without a clock edge
        hold_reset();
        pre[0] = 32'h000A0209;
        pre[1] = 32'h1;
        pre[2] = 32'hCAFEF00D;
        release_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rw_in_write", {31'd0, mem_rw}, 32'd1);
        check("wdata_in_write", mem_wdata, 32'hCAFEF00D);
        #2 rst = 1'b0;
        #1;
        check("async_rw_drop", {31'd0, mem_rw}, 32'd0);
        check("async_pc_zero", {28'd0, pc}, 32'd0);
        check("async_addr_zero", {16'd0, mem_addr}, 32'd0);
        check("async_busy_low", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        check("async_dst_unchanged", mem_val(4'd10), 32'd0);
        check("async_no_write", write_count, 0);
        check("async_not_halted", {31'd0, halted}, 32'd0);

        check("wdata_zero_outside_write", wdata_bad, 0);
        check("addr_high_bits_zero", addr_hi_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
